// File: rtl/ibex_muldiv_iter.sv
// ibex_muldiv_iter
//   Iterative RV32M multiply/divide unit that sits beside the ALU in EX.
//   A request is taken through a valid/ready handshake. Multiplies run a
//   radix-2 shift-add loop, and divides run a restoring-division loop, both
//   on operand magnitudes. The sign is applied on the last iteration, and the
//   result is held until the initiator accepts it.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   req_valid_i/ready_o   request handshake (ready only while idle)
//   op_i                  0 = MULL, 1 = MULH, 2 = DIV, 3 = REM
//   signed_mode_i         bit0: operand A signed, bit1: operand B signed
//   op_a_i, op_b_i        multiplicand/dividend, multiplier/divisor
//   kill_i                abort any in-flight operation, block acceptance
//   rsp_valid_o/ready_i   response handshake
//   result_o              registered result, stable while rsp_valid_o = 1
module ibex_muldiv_iter #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       op_i,
    input  logic [1:0]       signed_mode_i,
    input  logic [Width-1:0] op_a_i,
    input  logic [Width-1:0] op_b_i,
    input  logic             kill_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [Width-1:0] result_o
);

    localparam int unsigned CntW = $clog2(Width);
    localparam logic [Width-1:0] MinNeg = {1'b1, {(Width-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MD_MULL = 2'd0,
        MD_MULH = 2'd1,
        MD_DIV  = 2'd2,
        MD_REM  = 2'd3
    } md_op_e;

    state_e             state, state_next;
    md_op_e             op, op_in;
    logic               sign;
    logic [Width-1:0]   opnd;      // |A| for multiply, |B| for divide
    logic [2*Width-1:0] acc;       // {hi, lo} product or {remainder, quotient}
    logic [CntW-1:0]    cnt;
    logic [Width-1:0]   result;

    logic               sign_a, sign_b;
    logic [Width-1:0]   mag_a, mag_b;
    logic               is_div, div_zero, overflow, fast, accept;
    logic [Width-1:0]   fast_result;

    logic [Width:0]     mul_sum;
    logic [2*Width-1:0] mul_next;
    logic [Width:0]     div_tmp, div_diff;
    logic [2*Width-1:0] div_next;
    logic [2*Width-1:0] step, prod;
    logic [Width-1:0]   quot, rem;
    logic [Width-1:0]   calc_result;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign op_in    = md_op_e'(op_i);
    assign sign_a   = signed_mode_i[0] & op_a_i[Width-1];
    assign sign_b   = signed_mode_i[1] & op_b_i[Width-1];
    assign mag_a    = sign_a ? -op_a_i : op_a_i;
    assign mag_b    = sign_b ? -op_b_i : op_b_i;
    assign is_div   = op_i[1];
    assign div_zero = (op_b_i == '0);
    assign overflow = (signed_mode_i == 2'b11) && (op_a_i == MinNeg) && (op_b_i == '1);
    assign fast     = is_div && (div_zero || overflow);
    assign accept   = (state == IDLE) && req_valid_i && !kill_i;

    always_comb begin
        fast_result = '0;
        if (div_zero) begin
            fast_result = (op_in == MD_REM) ? op_a_i : '1;
        end else begin
            fast_result = (op_in == MD_REM) ? '0 : op_a_i;
        end
    end

    // ------------------------------------------------------------------
    // One iteration of either loop, plus sign application
    // ------------------------------------------------------------------
    always_comb begin
        // Multiply: the add is done one bit wider so its carry is shifted in
        // as the new accumulator MSB.
        mul_sum  = {1'b0, acc[2*Width-1:Width]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next = {mul_sum, acc[Width-1:1]};

        // Divide: shifted remainder can reach Width+1 bits; a set MSB of the
        // difference means the trial subtraction went negative.
        div_tmp  = {acc[2*Width-1:Width], acc[Width-1]};
        div_diff = div_tmp - {1'b0, opnd};
        if (div_diff[Width]) begin
            div_next = {div_tmp[Width-1:0], acc[Width-2:0], 1'b0};
        end else begin
            div_next = {div_diff[Width-1:0], acc[Width-2:0], 1'b1};
        end

        step = op[1] ? div_next : mul_next;
        prod = sign ? -mul_next : mul_next;
        quot = sign ? -div_next[Width-1:0] : div_next[Width-1:0];
        rem  = sign ? -div_next[2*Width-1:Width] : div_next[2*Width-1:Width];

        calc_result = '0;
        case (op)
            MD_MULL: calc_result = prod[Width-1:0];
            MD_MULH: calc_result = prod[2*Width-1:Width];
            MD_DIV:  calc_result = quot;
            MD_REM:  calc_result = rem;
            default: calc_result = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = fast ? DONE : CALC;
                end
            end
            CALC: begin
                if (kill_i) begin
                    state_next = IDLE;
                end else if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (kill_i || rsp_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op     <= MD_MULL;
            sign   <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
        end else if (accept) begin
            op   <= op_in;
            sign <= (op_in == MD_REM) ? sign_a : (sign_a ^ sign_b);
            opnd <= is_div ? mag_b : mag_a;
            acc  <= {{Width{1'b0}}, (is_div ? mag_a : mag_b)};
            cnt  <= CntW'(Width - 1);
            if (fast) begin
                result <= fast_result;
            end
        end else if (state == CALC && !kill_i) begin
            acc <= step;
            if (cnt == '0) begin
                result <= calc_result;
            end else begin
                cnt <= cnt - CntW'(1);
            end
        end
    end

    assign req_ready_o = (state == IDLE);
    assign rsp_valid_o = (state == DONE);
    assign result_o    = result;

endmodule

// File: tb/tb_ibex_muldiv_iter.sv
// Self-checking bench for ibex_muldiv_iter (Width = 32).
// Latency is counted in cycles with the handshake cycle as cycle 0:
// normal operations complete in cycle Width+1, fast paths in cycle 1.
module tb_ibex_muldiv_iter;

    localparam int unsigned W  = 32;
    localparam int          NV = 19;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    op;
    logic [1:0]    smode;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          kill;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  result;

    ibex_muldiv_iter #(.Width(W)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .op_i          (op),
        .signed_mode_i (smode),
        .op_a_i        (a),
        .op_b_i        (b),
        .kill_i        (kill),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .result_o      (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  sm;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [NV];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Present one request while idle, then wait (bounded) for rsp_valid.
    task automatic issue(input logic [1:0] o, input logic [1:0] sm, input logic [31:0] va,
                         input logic [31:0] vb, output logic [31:0] res, output int lat);
        @(negedge clk);
        op = o; smode = sm; a = va; b = vb; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
    endtask

    task automatic release_rsp();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res;
        int          lat;
        logic        seen;
        logic [31:0] held;

        //            op     sm     a             b             expected      lat
        vecs[0]  = '{2'd0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33};
        vecs[1]  = '{2'd1, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
        vecs[2]  = '{2'd1, 2'b01, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33};
        vecs[3]  = '{2'd1, 2'b11, 32'h80000000, 32'h80000000, 32'h40000000, 33};
        vecs[4]  = '{2'd2, 2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33};
        vecs[5]  = '{2'd3, 2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33};
        vecs[6]  = '{2'd2, 2'b00, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 33};
        vecs[7]  = '{2'd3, 2'b00, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 33};
        vecs[8]  = '{2'd2, 2'b00, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 1};
        vecs[9]  = '{2'd3, 2'b00, 32'h00001234, 32'h00000000, 32'h00001234, 1};
        vecs[10] = '{2'd2, 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[11] = '{2'd3, 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
        vecs[12] = '{2'd0, 2'b11, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFEB, 33};
        vecs[13] = '{2'd2, 2'b11, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 33};
        vecs[14] = '{2'd3, 2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33};
        vecs[15] = '{2'd2, 2'b01, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33};
        vecs[16] = '{2'd3, 2'b01, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33};
        vecs[17] = '{2'd1, 2'b10, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
        vecs[18] = '{2'd3, 2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 1};

        rst = 1'b1; req_valid = 1'b0; op = '0; smode = '0; a = '0; b = '0;
        kill = 1'b0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_req_ready", {31'b0, req_ready}, 32'd1);
        check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset_result", result, 32'd0);

        // Directed vector table
        for (int i = 0; i < NV; i++) begin
            issue(vecs[i].op, vecs[i].sm, vecs[i].a, vecs[i].b, res, lat);
            check($sformatf("v%0d_result", i), res, vecs[i].exp);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            release_rsp();
            check($sformatf("v%0d_rsp_drop", i), {31'b0, rsp_valid}, 32'd0);
            check($sformatf("v%0d_ready_back", i), {31'b0, req_ready}, 32'd1);
        end

        // Response held off for 10 cycles: everything stays put
        issue(2'd0, 2'b00, 32'd6, 32'd7, res, lat);
        check("hold_result", res, 32'd42);
        check("hold_latency", lat, 32'd33);
        held = result;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check($sformatf("hold%0d_result", i), result, held);
            check($sformatf("hold%0d_req_ready", i), {31'b0, req_ready}, 32'd0);
            check($sformatf("hold%0d_rsp_valid", i), {31'b0, rsp_valid}, 32'd1);
        end
        release_rsp();

        // Kill in CALC cycle 5
        @(negedge clk);
        op = 2'd0; smode = 2'b00; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("kill_busy", {31'b0, req_ready}, 32'd0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_idle_ready", {31'b0, req_ready}, 32'd1);
        check("kill_idle_valid", {31'b0, rsp_valid}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        check("kill_no_rsp", {31'b0, seen}, 32'd0);
        issue(2'd0, 2'b00, 32'd3, 32'd5, res, lat);
        check("after_kill_mull", res, 32'd15);
        check("after_kill_latency", lat, 32'd33);
        release_rsp();

        // Kill while DONE discards the response
        issue(2'd2, 2'b00, 32'd100, 32'd7, res, lat);
        check("div_100_7", res, 32'd14);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_done_valid", {31'b0, rsp_valid}, 32'd0);
        check("kill_done_ready", {31'b0, req_ready}, 32'd1);

        // Kill in IDLE blocks acceptance
        @(negedge clk);
        op = 2'd0; smode = 2'b00; a = 32'd2; b = 32'd2; req_valid = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; kill = 1'b0;
        check("kill_idle_block", {31'b0, req_ready}, 32'd1);

        // Asynchronous reset between edges while in CALC
        @(negedge clk);
        op = 2'd0; smode = 2'b00; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        check("areset_req_ready", {31'b0, req_ready}, 32'd1);
        check("areset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("areset_result", result, 32'd0);
        rst = 1'b0;
        issue(2'd3, 2'b00, 32'd10, 32'd3, res, lat);
        check("after_reset_rem", res, 32'd1);
        check("after_reset_latency", lat, 32'd33);
        release_rsp();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
